// File: rtl/sp_ram_arbiter_if.sv
// One requester's port onto the shared single-port RAM: command/handshake
// outward, grant and one-cycle-late response back.
interface sp_ram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    lock;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, addr, we, be, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two masters, with a
// one-cycle response pipe. Define SP_RAM_ARB_LOCK_EN to build bounded burst locking.
module sp_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                    clk,
    input  logic                    rst_i,
    sp_ram_arbiter_if.slave         m0,
    sp_ram_arbiter_if.slave         m1,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic                    busy_o
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("sp_ram_arbiter: MAX_BURST must be in 1..255");
    end

    logic prio, prio_n;
    logic rr0, rr1;
    logic g0_raw, g1_raw;
    logic gnt0, gnt1;
    logic rv, owner;

    // Plain round-robin pick; a lone requester always wins.
    assign rr0 = m0.req & (~m1.req | ~prio);
    assign rr1 = m1.req & ~rr0;

`ifdef SP_RAM_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam int unsigned    CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lk1, own_req, own_lock;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            prio  <= prio_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        g0_raw   = 1'b0;
        g1_raw   = 1'b0;
        state_n  = state;
        prio_n   = prio;
        cnt_n    = cnt;
        lk1      = 1'b0;
        own_req  = 1'b0;
        own_lock = 1'b0;
        case (state)
            IDLE: begin
                g0_raw = rr0;
                g1_raw = rr1;
                if (rr0 || rr1) begin
                    prio_n = rr0;
                    // A one-beat limit means every locked grant is already the last.
                    if ((rr0 ? m0.lock : m1.lock) && CNT_MAX > CNT_ONE) begin
                        state_n = rr0 ? LOCK0 : LOCK1;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            default: begin
                lk1      = (state == LOCK1);
                own_req  = lk1 ? m1.req  : m0.req;
                own_lock = lk1 ? m1.lock : m0.lock;
                g0_raw   = own_req & ~lk1;
                g1_raw   = own_req & lk1;
                if (own_req && cnt != CNT_MAX)
                    cnt_n = cnt + CNT_ONE;
                if (!own_lock || (own_req && cnt_n == CNT_MAX)) begin
                    state_n = IDLE;
                    prio_n  = ~lk1;
                    cnt_n   = '0;
                end
            end
        endcase
    end

    assign busy_o = rv | (state != IDLE);
`else
    logic unused_lock;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) prio <= 1'b0;
        else       prio <= prio_n;
    end

    always_comb begin
        g0_raw = rr0;
        g1_raw = rr1;
        prio_n = (rr0 | rr1) ? rr0 : prio;
    end

    assign unused_lock = m0.lock | m1.lock;
    assign busy_o      = rv;
`endif

    assign gnt0 = g0_raw & ~rst_i;
    assign gnt1 = g1_raw & ~rst_i;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rv    <= 1'b0;
            owner <= 1'b0;
        end else begin
            rv <= gnt0 | gnt1;
            if (gnt0 | gnt1)
                owner <= gnt1;
        end
    end

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rv & ~owner;
    assign m1.rvalid = rv & owner;
    assign m0.rdata  = m0.rvalid ? ram_rdata_i : '0;
    assign m1.rdata  = m1.rvalid ? ram_rdata_i : '0;

    assign ram_en_o    = gnt0 | gnt1;
    assign ram_we_o    = ram_en_o & (gnt1 ? m1.we : m0.we);
    assign ram_addr_o  = gnt1 ? m1.addr  : m0.addr;
    assign ram_be_o    = gnt1 ? m1.be    : m0.be;
    assign ram_wdata_o = gnt1 ? m1.wdata : m0.wdata;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: vector table plus lock and reset sequences,
// with responses checked against a scoreboard queue and a shadow memory.
module tb_sp_ram_arbiter;
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
`ifdef SP_RAM_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    typedef struct {
        logic          r0, w0, l0;
        logic [AW-1:0] a0;
        logic [BW-1:0] b0;
        logic [DW-1:0] d0;
        logic          r1, w1, l1;
        logic [AW-1:0] a1;
        logic [BW-1:0] b1;
        logic [DW-1:0] d1;
        logic          eg0, eg1;
    } vec_t;

    typedef struct {
        logic          valid, owner, chk;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_be;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;

    logic [DW-1:0] mem [0:8191] = '{default: '0};
    logic [DW-1:0] exp_mem [0:8191];
    rsp_t          q[$];
    vec_t          tbl [14];
    int            n_vec = 0;
    int            n_bad = 0;

    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .m0          (m0_if.slave),
        .m1          (m1_if.slave),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_be_o    (ram_be),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, byte-enabled writes, 0xDEADBEEF preloaded at 0x0010.
    always @(posedge clk) begin
        if (rst_i) begin
            mem[4] <= 32'hDEADBEEF;
        end else if (ram_en) begin
            if (ram_we)
                for (int b = 0; b < BW; b++)
                    if (ram_be[b]) mem[ram_addr[14:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr[14:2]];
        end
    end

    task automatic cmp1(input logic act, input logic exp, input string nm);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmpw(input logic [DW-1:0] act, input logic [DW-1:0] exp, input string nm);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t v2(logic r0, logic [AW-1:0] a0, logic r1, logic [AW-1:0] a1,
                                logic eg0, logic eg1);
        vec_t v;
        v.r0 = r0; v.w0 = 1'b0; v.l0 = 1'b0; v.a0 = a0; v.b0 = '1; v.d0 = '0;
        v.r1 = r1; v.w1 = 1'b0; v.l1 = 1'b0; v.a1 = a1; v.b1 = '1; v.d1 = '0;
        v.eg0 = eg0; v.eg1 = eg1;
        return v;
    endfunction

    task automatic check_resp(input string nm);
        rsp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            cmp1(m0_if.rvalid, e.valid & ~e.owner, {nm, ".rvalid0"});
            cmp1(m1_if.rvalid, e.valid & e.owner, {nm, ".rvalid1"});
            if (e.valid && e.chk)
                cmpw(e.owner ? m1_if.rdata : m0_if.rdata, e.data, {nm, ".rdata"});
            if (!e.valid || e.owner)  cmpw(m0_if.rdata, '0, {nm, ".rdata0_idle"});
            if (!e.valid || !e.owner) cmpw(m1_if.rdata, '0, {nm, ".rdata1_idle"});
        end
    endtask

    task automatic drive_check(input vec_t v, input string nm);
        rsp_t          e;
        logic          g, gw;
        logic [AW-1:0] ga;
        logic [BW-1:0] gb;
        logic [DW-1:0] gd;
        m0_if.req = v.r0; m0_if.we = v.w0; m0_if.lock = v.l0;
        m0_if.addr = v.a0; m0_if.be = v.b0; m0_if.wdata = v.d0;
        m1_if.req = v.r1; m1_if.we = v.w1; m1_if.lock = v.l1;
        m1_if.addr = v.a1; m1_if.be = v.b1; m1_if.wdata = v.d1;
        #1;
        cmp1(m0_if.gnt, v.eg0, {nm, ".gnt0"});
        cmp1(m1_if.gnt, v.eg1, {nm, ".gnt1"});
        g  = v.eg0 | v.eg1;
        cmp1(ram_en, g, {nm, ".ram_en"});
        ga = v.eg1 ? v.a1 : v.a0;
        gb = v.eg1 ? v.b1 : v.b0;
        gd = v.eg1 ? v.d1 : v.d0;
        gw = g & (v.eg1 ? v.w1 : v.w0);
        if (g) begin
            cmpw(DW'(ram_addr), DW'(ga), {nm, ".ram_addr"});
            cmp1(ram_we, gw, {nm, ".ram_we"});
        end
        e.valid = g;
        e.owner = v.eg1;
        e.chk   = ~gw;
        e.data  = exp_mem[ga[14:2]];
        q.push_back(e);
        if (gw)
            for (int b = 0; b < BW; b++)
                if (gb[b]) exp_mem[ga[14:2]][8*b +: 8] = gd[8*b +: 8];
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(posedge clk);
        #1;
        check_resp(nm);
        drive_check(v, nm);
    endtask

    initial begin
        vec_t v;
        exp_mem    = '{default: '0};
        exp_mem[4] = 32'hDEADBEEF;

        tbl[0]  = v2(0, 15'h0000, 1, 15'h0020, 0, 1);
        tbl[1]  = v2(1, 15'h0010, 0, 15'h0000, 1, 0);
        tbl[2]  = v2(0, 15'h0000, 0, 15'h0000, 0, 0);
        tbl[3]  = v2(0, 15'h0000, 1, 15'h0100, 0, 1);
        tbl[3].w1 = 1'b1; tbl[3].b1 = 4'b0011; tbl[3].d1 = 32'h12345678;
        tbl[4]  = v2(1, 15'h0100, 0, 15'h0000, 1, 0);
        tbl[5]  = v2(0, 15'h0000, 0, 15'h0000, 0, 0);
        tbl[6]  = v2(0, 15'h0000, 1, 15'h0020, 0, 1);
        for (int unsigned i = 0; i < 6; i++)
            tbl[7+i] = v2(1, 15'h0010, 1, 15'h0100, (i % 2) == 0, (i % 2) == 1);
        tbl[13] = v2(0, 15'h0000, 0, 15'h0000, 0, 0);

        // Reset held with both masters requesting.
        rst_i = 1'b1;
        v = v2(1, 15'h0010, 1, 15'h0020, 0, 0);
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.lock = 1'b0;
        m0_if.addr = v.a0; m0_if.be = '1; m0_if.wdata = '0;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.lock = 1'b0;
        m1_if.addr = v.a1; m1_if.be = '1; m1_if.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        cmp1(m0_if.gnt, 1'b0, "rst.gnt0");
        cmp1(m1_if.gnt, 1'b0, "rst.gnt1");
        cmp1(ram_en, 1'b0, "rst.ram_en");
        cmp1(m0_if.rvalid, 1'b0, "rst.rvalid0");
        cmp1(m1_if.rvalid, 1'b0, "rst.rvalid1");
        cmp1(busy, 1'b0, "rst.busy");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        drive_check(v2(1, 15'h0010, 1, 15'h0020, 1, 0), "rst_release");

        for (int unsigned i = 0; i < 14; i++)
            apply(tbl[i], $sformatf("tbl%0d", i));

        // m1 holds lock for 12 beats while m0 waits; then lock released with no request.
        for (int c = 1; c <= 16; c++) begin
            v = v2(LOCK_ON ? (c >= 2 && c <= 9) : (c == 2), 15'h0100,
                   c <= 13, 15'h0010,
                   LOCK_ON ? (c == 9) : (c == 2),
                   LOCK_ON ? ((c <= 8) || (c >= 10 && c <= 13)) : ((c == 1) || (c >= 3 && c <= 13)));
            v.l1 = (c <= 14);
            apply(v, $sformatf("lock%0d", c));
            if (c == 15) cmp1(busy, LOCK_ON, "lock15.busy");
            if (c == 16) cmp1(busy, 1'b0, "lock16.busy");
        end

        // Reset pulsed on beat 3 of an m0 burst.
        for (int c = 1; c <= 3; c++) begin
            v = v2(1, 15'h0010, 0, 15'h0000, 1, 0);
            v.l0 = 1'b1;
            apply(v, $sformatf("burst%0d", c));
        end
        rst_i = 1'b1;
        #1;
        q.delete();
        cmp1(m0_if.gnt, 1'b0, "midrst.gnt0");
        cmp1(ram_en, 1'b0, "midrst.ram_en");
        cmp1(busy, 1'b0, "midrst.busy");
        cmp1(m0_if.rvalid, 1'b0, "midrst.rvalid0");
        @(posedge clk);
        #1;
        cmp1(m0_if.rvalid, 1'b0, "midrst.rvalid0_late");
        rst_i = 1'b0;
        drive_check(v2(1, 15'h0010, 1, 15'h0020, 1, 0), "postrst.both");
        apply(v2(0, 15'h0000, 1, 15'h0020, 0, 1), "postrst.m1");
        apply(v2(0, 15'h0000, 0, 15'h0000, 0, 0), "flush0");
        apply(v2(0, 15'h0000, 0, 15'h0000, 0, 0), "flush1");
        cmp1(busy, 1'b0, "final.busy");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
